interlayer_gradient_buffer: RTL and testbench

- Backward-pass counterpart of the forward interlayer activation buffer.
- Collects error-gradient contributions from the layer-(L+1) backward unit (N_LANES_I lanes per beat, each tagged with a neuron id) and accumulates them per neuron over PASSES full sweeps.
- When accumulation completes, streams the summed gradients to the layer-L backward unit LOOPS times, clearing each entry on its final read.
- Also provides a random-access read port for the weight-update unit.

---
 rtl/interlayer_gradient_buffer_pkg.sv | 33 +++
 rtl/interlayer_gradient_buffer_grad_sat_accum_bank.sv | 46 ++++
 rtl/interlayer_gradient_buffer.sv | 170 +++++++++++++++++
 tb/tb_interlayer_gradient_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/interlayer_gradient_buffer_pkg.sv
// rtl/interlayer_gradient_buffer_pkg.sv - shared backward-layer types and saturating arithmetic
`ifndef PREC
`define PREC 16
`endif

package interlayer_gradient_buffer_pkg;

    localparam int PREC_W = `PREC;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } grad_state_t;

    localparam logic signed [PREC_W-1:0] SAT_MAX = {1'b0, {(PREC_W-1){1'b1}}};
    localparam logic signed [PREC_W-1:0] SAT_MIN = {1'b1, {(PREC_W-1){1'b0}}};

    // Signed add that clamps at the representable extremes instead of wrapping.
    function automatic logic signed [PREC_W-1:0] sat_add(
        input logic signed [PREC_W-1:0] a,
        input logic signed [PREC_W-1:0] b
    );
        logic signed [PREC_W:0] s;
        s = {a[PREC_W-1], a} + {b[PREC_W-1], b};
        if (s[PREC_W] != s[PREC_W-1]) begin
            sat_add = s[PREC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = s[PREC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/interlayer_gradient_buffer_grad_sat_accum_bank.sv
// rtl/interlayer_gradient_buffer_grad_sat_accum_bank.sv - per-neuron saturating accumulator register bank
module grad_sat_accum_bank
    import interlayer_gradient_buffer_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int ID_WIDTH  = 5,
    parameter int BUFF_SIZE = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               acc_en_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]   acc_id_i,
    input  logic [N_PORTS-1:0][PREC_W-1:0]     acc_val_i,
    input  logic                               clr_en_i,
    input  logic [ID_WIDTH-1:0]                clr_id_i,
    input  logic [ID_WIDTH-1:0]                rd_a_id_i,
    output logic [PREC_W-1:0]                  rd_a_data_o,
    input  logic [ID_WIDTH-1:0]                rd_b_id_i,
    output logic [PREC_W-1:0]                  rd_b_data_o
);

    logic [PREC_W-1:0] mem_q [BUFF_SIZE];

    // Entry update: every port adds into the old value; a later port to the
    // same id overrides an earlier one, so the highest lane wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < BUFF_SIZE; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            if (clr_en_i) begin
                mem_q[clr_id_i] <= '0;
            end
            if (acc_en_i) begin
                for (int p = 0; p < N_PORTS; p++) begin
                    mem_q[acc_id_i[p]] <= sat_add(mem_q[acc_id_i[p]], acc_val_i[p]);
                end
            end
        end
    end

    assign rd_a_data_o = mem_q[rd_a_id_i];
    assign rd_b_data_o = mem_q[rd_b_id_i];

endmodule

// File: rtl/interlayer_gradient_buffer.sv
// rtl/interlayer_gradient_buffer.sv - gradient accumulate-then-stream buffer between backward layers
module interlayer_gradient_buffer
    import interlayer_gradient_buffer_pkg::*;
#(
    parameter int N_LANES_I = 4,
    parameter int N_LANES_O = 2,
    parameter int ID_WIDTH  = 5,
    parameter int BUFF_SIZE = 32,
    parameter int PASSES    = 4,
    parameter int LOOPS     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_LANES_I-1:0][`PREC-1:0]      grad_i,
    input  logic [N_LANES_I-1:0][ID_WIDTH-1:0]   grad_id_i,
    input  logic                                 valid_grad_i,
    output logic                                 in_rdy_o,
    output logic [N_LANES_O-1:0][`PREC-1:0]      grad_o,
    output logic [ID_WIDTH-1:0]                  grad_id_o,
    output logic                                 valid_o,
    input  logic [ID_WIDTH-1:0]                  r_ptr,
    output logic [`PREC-1:0]                     r_grad_o,
    output logic                                 buff_rdy,
    output logic                                 err_o
);

    localparam int PASS_W = $clog2(PASSES + 1);
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(BUFF_SIZE - 1);
    localparam logic [PASS_W-1:0]   PASS_LAST = PASS_W'(PASSES);
    localparam logic [LOOP_W-1:0]   LOOP_LAST = LOOP_W'(LOOPS - 1);

    grad_state_t          state_q, state_d;
    logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [ID_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOOP_W-1:0]    loop_cnt_q, loop_cnt_d;
    logic                 err_q, err_d;
    logic                 buff_rdy_q, buff_rdy_d;
    logic                 valid_q, valid_d;
    logic [PREC_W-1:0]    grad_q, grad_d;
    logic [ID_WIDTH-1:0]  grad_id_q, grad_id_d;
    logic [PREC_W-1:0]    r_grad_q;

    logic                 acc_en;
    logic                 clr_en;
    logic [PREC_W-1:0]    drain_data;
    logic [PREC_W-1:0]    rand_data;

    grad_sat_accum_bank #(
        .N_PORTS   (N_LANES_I),
        .ID_WIDTH  (ID_WIDTH),
        .BUFF_SIZE (BUFF_SIZE)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .acc_en_i    (acc_en),
        .acc_id_i    (grad_id_i),
        .acc_val_i   (grad_i),
        .clr_en_i    (clr_en),
        .clr_id_i    (rd_ptr_q),
        .rd_a_id_i   (rd_ptr_q),
        .rd_a_data_o (drain_data),
        .rd_b_id_i   (r_ptr),
        .rd_b_data_o (rand_data)
    );

    // Next-state and datapath control: accumulate sweeps, wait, then stream LOOPS times.
    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        loop_cnt_d = loop_cnt_q;
        err_d      = err_q;
        buff_rdy_d = buff_rdy_q;
        valid_d    = 1'b0;
        grad_d     = grad_q;
        grad_id_d  = grad_id_q;
        acc_en     = 1'b0;
        clr_en     = 1'b0;

        case (state_q)
            ACCUM: begin
                if (valid_grad_i) begin
                    acc_en = 1'b1;
                    if (grad_id_i[N_LANES_I-1] == LAST_ID) begin
                        pass_cnt_d = pass_cnt_q + PASS_W'(1);
                        if (pass_cnt_d == PASS_LAST) begin
                            state_d    = FULL;
                            buff_rdy_d = 1'b1;
                        end
                    end
                end
            end
            FULL: begin
                if (valid_grad_i) begin
                    err_d = 1'b1;
                end
                if (start) begin
                    state_d    = DRAIN;
                    rd_ptr_d   = '0;
                    loop_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (valid_grad_i) begin
                    err_d = 1'b1;
                end
                valid_d   = 1'b1;
                grad_d    = drain_data;
                grad_id_d = rd_ptr_q;
                // Final loop empties the buffer as it streams, ready for the next batch.
                clr_en    = (loop_cnt_q == LOOP_LAST);
                if (rd_ptr_q == LAST_ID) begin
                    rd_ptr_d = '0;
                    if (loop_cnt_q == LOOP_LAST) begin
                        state_d    = ACCUM;
                        pass_cnt_d = '0;
                        buff_rdy_d = 1'b0;
                        loop_cnt_d = '0;
                    end else begin
                        loop_cnt_d = loop_cnt_q + LOOP_W'(1);
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + ID_WIDTH'(1);
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            pass_cnt_q <= '0;
            rd_ptr_q   <= '0;
            loop_cnt_q <= '0;
            err_q      <= 1'b0;
            buff_rdy_q <= 1'b0;
            valid_q    <= 1'b0;
            grad_q     <= '0;
            grad_id_q  <= '0;
            r_grad_q   <= '0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            loop_cnt_q <= loop_cnt_d;
            err_q      <= err_d;
            buff_rdy_q <= buff_rdy_d;
            valid_q    <= valid_d;
            grad_q     <= grad_d;
            grad_id_q  <= grad_id_d;
            r_grad_q   <= rand_data;
        end
    end

    assign in_rdy_o  = (state_q == ACCUM);
    assign grad_o    = {N_LANES_O{grad_q}};
    assign grad_id_o = grad_id_q;
    assign valid_o   = valid_q;
    assign r_grad_o  = r_grad_q;
    assign buff_rdy  = buff_rdy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_interlayer_gradient_buffer.sv
// tb/tb_interlayer_gradient_buffer.sv - directed self-checking bench for interlayer_gradient_buffer
`ifndef PREC
`define PREC 16
`endif

module tb_interlayer_gradient_buffer;

    localparam int W = 16;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [3:0][W-1:0]     grad_i;
    logic [3:0][4:0]       grad_id_i;
    logic                  valid_grad_i;
    logic                  in_rdy_o;
    logic [1:0][W-1:0]     grad_o;
    logic [4:0]            grad_id_o;
    logic                  valid_o;
    logic [4:0]            r_ptr;
    logic [W-1:0]          r_grad_o;
    logic                  buff_rdy;
    logic                  err_o;

    int checks = 0;
    int errors = 0;

    interlayer_gradient_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .grad_i       (grad_i),
        .grad_id_i    (grad_id_i),
        .valid_grad_i (valid_grad_i),
        .in_rdy_o     (in_rdy_o),
        .grad_o       (grad_o),
        .grad_id_o    (grad_id_o),
        .valid_o      (valid_o),
        .r_ptr        (r_ptr),
        .r_grad_o     (r_grad_o),
        .buff_rdy     (buff_rdy),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][W-1:0] grad;
        logic [3:0][4:0]   id;
        logic              valid;
        logic [4:0]        rptr;
        logic [W-1:0]      exp_r_grad;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are read at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic fill(input logic start_on_last);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 8; k++) begin
                for (int l = 0; l < 4; l++) begin
                    grad_id_i[l] = 5'(4 * k + l);
                    grad_i[l]    = 16'd1;
                end
                check("in_rdy_accum", in_rdy_o, 1);
                valid_grad_i = 1'b1;
                start = start_on_last && (p == 3) && (k == 7);
                cycle();
                valid_grad_i = 1'b0;
                start = 1'b0;
                check("buff_rdy_fill", buff_rdy, (p == 3) && (k == 7));
            end
        end
    endtask

    task automatic read_all(input logic [W-1:0] expv);
        for (int e = 0; e < 32; e++) begin
            r_ptr = 5'(e);
            cycle();
            check("r_grad_entry", r_grad_o, expv);
        end
    endtask

    task automatic drain(input logic [W-1:0] expv, input logic inject);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("drain_latency_valid", valid_o, 0);
        check("in_rdy_drain", in_rdy_o, 0);
        for (int i = 0; i < 64; i++) begin
            if (inject && i < 5) begin
                valid_grad_i = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    grad_i[l]    = 16'd100;
                    grad_id_i[l] = 5'(l);
                end
            end
            cycle();
            valid_grad_i = 1'b0;
            check("drain_valid", valid_o, 1);
            check("drain_id", grad_id_o, i % 32);
            check("drain_lane0", grad_o[0], expv);
            check("drain_lane1", grad_o[1], expv);
            if (inject && i == 5) check("err_set", err_o, 1);
        end
        cycle();
        check("drain_end_valid", valid_o, 0);
        check("drain_end_in_rdy", in_rdy_o, 1);
        check("drain_end_buff_rdy", buff_rdy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        grad_i = '0;
        grad_id_i = '0;
        valid_grad_i = 1'b0;
        r_ptr = '0;

        // Saturation, duplicate-id and read-before-write vectors.
        vecs[0] = '{grad: {16'h7FFF, 16'h0, 16'h0, 16'h0}, id: {5'd3, 5'd2, 5'd1, 5'd0}, valid: 1, rptr: 5'd3, exp_r_grad: 16'h0000};
        vecs[1] = '{grad: {16'h7FFF, 16'h0, 16'h0, 16'h0}, id: {5'd3, 5'd2, 5'd1, 5'd0}, valid: 1, rptr: 5'd3, exp_r_grad: 16'h7FFF};
        vecs[2] = '{grad: {16'h0, 16'h0, 16'h0, 16'h0},    id: {5'd3, 5'd2, 5'd1, 5'd0}, valid: 0, rptr: 5'd3, exp_r_grad: 16'h7FFF};
        vecs[3] = '{grad: {16'h0, 16'h0, 16'h8000, 16'h0}, id: {5'd7, 5'd6, 5'd5, 5'd4}, valid: 1, rptr: 5'd5, exp_r_grad: 16'h0000};
        vecs[4] = '{grad: {16'h0, 16'h0, 16'h8000, 16'h0}, id: {5'd7, 5'd6, 5'd5, 5'd4}, valid: 1, rptr: 5'd5, exp_r_grad: 16'h8000};
        vecs[5] = '{grad: {16'h0, 16'h0, 16'h0, 16'h0},    id: {5'd7, 5'd6, 5'd5, 5'd4}, valid: 0, rptr: 5'd5, exp_r_grad: 16'h8000};
        vecs[6] = '{grad: {16'h0, 16'h0, 16'h2, 16'h1},    id: {5'd11, 5'd10, 5'd9, 5'd9}, valid: 1, rptr: 5'd9, exp_r_grad: 16'h0000};
        vecs[7] = '{grad: {16'h0, 16'h0, 16'h0, 16'h0},    id: {5'd11, 5'd10, 5'd9, 5'd9}, valid: 0, rptr: 5'd9, exp_r_grad: 16'h0002};
        vecs[8] = '{grad: {16'h0, 16'h0, 16'h0, 16'hFFFF}, id: {5'd14, 5'd13, 5'd12, 5'd3}, valid: 1, rptr: 5'd3, exp_r_grad: 16'h7FFF};
        vecs[9] = '{grad: {16'h0, 16'h0, 16'h0, 16'h0},    id: {5'd14, 5'd13, 5'd12, 5'd3}, valid: 0, rptr: 5'd3, exp_r_grad: 16'h7FFE};

        @(negedge clk);
        cycle();
        check("rst_valid", valid_o, 0);
        check("rst_grad_id", grad_id_o, 0);
        check("rst_grad", grad_o, 0);
        check("rst_r_grad", r_grad_o, 0);
        check("rst_buff_rdy", buff_rdy, 0);
        check("rst_err", err_o, 0);
        check("rst_in_rdy", in_rdy_o, 1);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            grad_i       = vecs[v].grad;
            grad_id_i    = vecs[v].id;
            valid_grad_i = vecs[v].valid;
            r_ptr        = vecs[v].rptr;
            cycle();
            check($sformatf("vec%0d_r_grad", v), r_grad_o, vecs[v].exp_r_grad);
            check($sformatf("vec%0d_in_rdy", v), in_rdy_o, 1);
            check($sformatf("vec%0d_buff_rdy", v), buff_rdy, 0);
        end
        valid_grad_i = 1'b0;

        // Four full +1 sweeps, then a normal drain.
        do_reset();
        fill(1'b0);
        r_ptr = 5'd7;
        cycle();
        check("full_r_grad7", r_grad_o, 16'd4);
        check("full_in_rdy", in_rdy_o, 0);
        check("full_buff_rdy", buff_rdy, 1);
        drain(16'd4, 1'b0);
        check("no_err_clean", err_o, 0);
        read_all(16'd0);

        // Start coincident with the final beat is ignored; a later start drains,
        // and inputs offered during the drain are dropped and flagged.
        fill(1'b1);
        cycle();
        check("ignored_start_valid", valid_o, 0);
        check("ignored_start_buff_rdy", buff_rdy, 1);
        cycle();
        check("ignored_start_valid2", valid_o, 0);
        drain(16'd4, 1'b1);
        check("err_sticky", err_o, 1);
        read_all(16'd0);
        check("err_sticky_after", err_o, 1);

        // Reset in the middle of a drain aborts it.
        fill(1'b0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("mid_drain_id", grad_id_o, 9);
        check("mid_drain_valid", valid_o, 1);
        rst = 1'b1;
        cycle();
        check("abort_valid", valid_o, 0);
        check("abort_grad_id", grad_id_o, 0);
        check("abort_grad", grad_o, 0);
        check("abort_r_grad", r_grad_o, 0);
        check("abort_buff_rdy", buff_rdy, 0);
        check("abort_err", err_o, 0);
        check("abort_in_rdy", in_rdy_o, 1);
        rst = 1'b0;
        cycle();
        check("abort_valid_after", valid_o, 0);
        read_all(16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
